// File: rtl/mc_control_unit.sv
// Multicycle control unit: Moore main FSM plus ALU decoder for a 32-bit datapath.
// Define MC_CONTROL_SLT_EN to decode funct 101010 (SLT); without it SLT is illegal.
module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_FUNCT = 2'd2
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101: funct_supported = 1'b1;
`ifdef MC_CONTROL_SLT_EN
            6'b101010: funct_supported = 1'b1;
`endif
            default: funct_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_supported(input logic [5:0] o);
        case (o)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
            default: op_supported = 1'b0;
        endcase
    endfunction

    state_e     state_q;
    state_e     state_d;
    alu_class_e alu_class_s;
    logic       pc_write_s;
    logic       branch_s;

    assign state = state_q;

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE: begin
                if (funct_supported(funct)) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs; everything is held inactive while reset is asserted
    always_comb begin
        alu_class_s = CLS_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            alu_class_s = CLS_ADD;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_write   = 1'b1;
                    pc_write_s = 1'b1;
                    alu_src_b  = 2'b01;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = ~op_supported(op);
                end
                S_MEMADR, S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: i_or_d = 1'b1;
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a   = 1'b1;
                    alu_class_s = CLS_FUNCT;
                    illegal     = ~funct_supported(funct);
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_class_s = CLS_SUB;
                    pc_src      = 2'b01;
                    branch_s    = 1'b1;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write_s = 1'b1;
                end
                default: alu_class_s = CLS_ADD;
            endcase
        end
        pc_en = pc_write_s | (branch_s & zero);
    end

    // ALU decoder; unsupported funct falls back to ADD
    always_comb begin
        alu_control = 3'b010;
        case (alu_class_s)
            CLS_SUB: alu_control = 3'b110;
            CLS_FUNCT: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
`ifdef MC_CONTROL_SLT_EN
                    6'b101010: alu_control = 3'b111;
`endif
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized self-checking bench for mc_control_unit against an instruction-level model.
module tb_mc_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    int checks_cnt;
    int errors_cnt;

    localparam logic [15:0] RESET_WORD = {3'b010, 13'b0};

    mc_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .i_or_d(i_or_d), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] actual_ctrl();
        return {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
                ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal};
    endfunction

    // Model: which funct codes the ALU decoder accepts and what they select
    function automatic logic funct_ok(input logic [5:0] f);
        if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25) return 1'b1;
`ifdef MC_CONTROL_SLT_EN
        if (f == 6'h2a) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        if (f == 6'h22) return 3'b110;
        if (f == 6'h24) return 3'b000;
        if (f == 6'h25) return 3'b001;
`ifdef MC_CONTROL_SLT_EN
        if (f == 6'h2a) return 3'b111;
`endif
        return 3'b010;
    endfunction

    function automatic logic op_ok(input logic [5:0] o);
        return (o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02);
    endfunction

    // Model: expected FETCH-to-FETCH step sequence for one instruction
    task automatic instr_steps(input logic [5:0] o, input logic [5:0] f, output int q[$]);
        q = {0, 1};
        case (o)
            6'h23:   q = {q, 2, 3, 4};
            6'h2b:   q = {q, 2, 5};
            6'h00:   q = funct_ok(f) ? {q, 6, 7} : {q, 6};
            6'h04:   q = {q, 8};
            6'h08:   q = {q, 9, 10};
            6'h02:   q = {q, 11};
            default: q = q;
        endcase
    endtask

    // Model: control word the datapath should see in step s
    function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] o,
                                             input logic [5:0] f, input logic z);
        logic [2:0] ac;
        logic       a, pw, br, iord, irw, mw, rw, rd, m2r, ill;
        logic [1:0] b, ps;
        ac = 3'b010; a = 1'b0; b = 2'b00; ps = 2'b00; pw = 1'b0; br = 1'b0;
        iord = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
        case (s)
            0:  begin irw = 1'b1; pw = 1'b1; b = 2'b01; end
            1:  begin b = 2'b11; ill = ~op_ok(o); end
            2:  begin a = 1'b1; b = 2'b10; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin a = 1'b1; ac = funct_alu(f); ill = ~funct_ok(f); end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin a = 1'b1; ac = 3'b110; ps = 2'b01; br = 1'b1; end
            9:  begin a = 1'b1; b = 2'b10; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pw = 1'b1; end
            default: ac = 3'b010;
        endcase
        return {ac, a, b, ps, pw | (br & z), iord, irw, mw, rw, rd, m2r, ill};
    endfunction

    // One cycle: apply inputs after the falling edge, check, advance one clock
    task automatic step(input int s, input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
        #1;
        check_val("state", 32'(state), 32'(s));
        check_val($sformatf("ctrl_s%0d_op%h_f%h", s, o, f), 32'(actual_ctrl()), 32'(exp_ctrl(s, o, f, z)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        int q[$];
        logic z;
        instr_steps(o, f, q);
        foreach (q[i]) begin
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            step(q[i], o, f, z);
        end
    endtask

    task automatic reset_check(input string tag);
        #1;
        check_val({tag, "_ctrl"}, 32'(actual_ctrl()), 32'(RESET_WORD));
    endtask

    logic [5:0] ops_tbl[7];
    logic [5:0] fun_tbl[6];

    initial begin
        logic [5:0] ro, rf;
        checks_cnt = 0;
        errors_cnt = 0;
        reset = 1'b1; op = 6'h23; funct = 6'h20; zero = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("rst");
        check_val("rst_state", 32'(state), 32'd0);
        reset = 1'b0;

        run_instr(6'h23, 6'h00, 2);
        run_instr(6'h00, 6'h22, 2);
        run_instr(6'h00, 6'h20, 2);
        run_instr(6'h00, 6'h24, 2);
        run_instr(6'h00, 6'h25, 2);
        run_instr(6'h04, 6'h00, 1);
        run_instr(6'h04, 6'h00, 0);
        run_instr(6'h3f, 6'h20, 1);
        run_instr(6'h00, 6'h2a, 2);
        run_instr(6'h2b, 6'h00, 2);
        run_instr(6'h08, 6'h00, 2);
        run_instr(6'h02, 6'h00, 2);

        // Abort an lw in MEMRD and make sure no MEMWB write follows
        step(0, 6'h23, 6'h00, 1'b0);
        step(1, 6'h23, 6'h00, 1'b0);
        step(2, 6'h23, 6'h00, 1'b0);
        reset = 1'b1;
        reset_check("rst_memrd");
        @(posedge clk);
        @(negedge clk);
        reset_check("rst_hold");
        check_val("rst_hold_state", 32'(state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'h23, 6'h00, 2);

        ops_tbl = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3f};
        fun_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        for (int n = 0; n < 300; n++) begin
            ro = ops_tbl[$urandom_range(6, 0)];
            if (ro == 6'h3f) ro = 6'($urandom);
            rf = fun_tbl[$urandom_range(5, 0)];
            if (rf == 6'h00) rf = 6'($urandom);
            run_instr(ro, rf, 2);
            if ($urandom_range(19, 0) == 0) begin
                reset = 1'b1;
                reset_check("rst_rand");
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
